// File: rtl/play_arbiter.sv
// Output arbiter for the piano buzzer/LEDs: picks the note source named by the one-hot
// mode switches, mutes across mode changes and inserts a short gap between distinct notes.
module play_arbiter #(
  parameter int MUTE_CYCLES = 1_000_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode,
  input  logic [3:0] note_free,
  input  logic [6:0] led_free,
  input  logic [3:0] note_auto,
  input  logic [6:0] led_auto,
  input  logic [3:0] note_learn,
  input  logic [6:0] led_learn,
  output logic [3:0] note_out,
  output logic [6:0] led_out,
  output logic [2:0] grant,
  output logic       switching
);

  typedef enum logic [1:0] {IDLE, MUTE, PLAY, GAP} state_t;

  localparam logic [CNT_W-1:0] MUTE_LAST = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [2:0]       mode_meta;
  logic [2:0]       mode_s;
  logic [2:0]       active_mode;
  logic [3:0]       cur_note;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       src_note;
  logic [6:0]       src_led;
  logic             mode_onehot;

  always_comb begin
    src_note = 4'd0;
    src_led  = 7'd0;
    case (active_mode)
      3'b100: begin src_note = note_free;  src_led = led_free;  end
      3'b010: begin src_note = note_auto;  src_led = led_auto;  end
      3'b001: begin src_note = note_learn; src_led = led_learn; end
      default: ;
    endcase
  end

  assign mode_onehot = (mode_s == 3'b100) || (mode_s == 3'b010) || (mode_s == 3'b001);

  // Outputs are registered from the state being entered, so switching rises on the
  // same edge that enters MUTE and grant drops on that edge too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta   <= 3'b000;
      mode_s      <= 3'b000;
      state       <= IDLE;
      active_mode <= 3'b000;
      cur_note    <= 4'd0;
      cnt         <= '0;
      note_out    <= 4'd0;
      led_out     <= 7'd0;
      grant       <= 3'b000;
      switching   <= 1'b0;
    end else begin
      mode_meta <= mode;
      mode_s    <= mode_meta;
      if (mode_s != active_mode) begin
        active_mode <= mode_s;
        cnt         <= '0;
        state       <= mode_onehot ? MUTE : IDLE;
        note_out    <= 4'd0;
        led_out     <= 7'd0;
        grant       <= 3'b000;
        switching   <= mode_onehot;
      end else begin
        case (state)
          IDLE: begin
            note_out  <= 4'd0;
            led_out   <= 7'd0;
            grant     <= 3'b000;
            switching <= 1'b0;
          end
          MUTE: begin
            note_out <= 4'd0;
            if (cnt == MUTE_LAST) begin
              cur_note  <= src_note;
              cnt       <= '0;
              state     <= PLAY;
              led_out   <= src_led;
              grant     <= active_mode;
              switching <= 1'b0;
            end else begin
              cnt       <= cnt + 1'b1;
              led_out   <= 7'd0;
              grant     <= 3'b000;
              switching <= 1'b1;
            end
          end
          PLAY: begin
            led_out   <= src_led;
            grant     <= active_mode;
            switching <= 1'b0;
            note_out  <= cur_note;
            if (src_note != cur_note) begin
              cur_note <= src_note;
              // Two audible notes back to back get a silent gap between them.
              if (src_note != 4'd0 && cur_note != 4'd0) begin
                cnt      <= '0;
                state    <= GAP;
                note_out <= 4'd0;
              end
            end
          end
          GAP: begin
            led_out   <= src_led;
            grant     <= active_mode;
            switching <= 1'b0;
            cur_note  <= src_note;
            if (cnt == GAP_LAST) begin
              cnt      <= '0;
              state    <= PLAY;
              note_out <= cur_note;
            end else begin
              cnt      <= cnt + 1'b1;
              note_out <= 4'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_play_arbiter.sv
// Directed bench for play_arbiter with MUTE_CYCLES=8, GAP_CYCLES=4.
module tb_play_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [3:0] note_free = 4'd9, note_auto = 4'd0, note_learn = 4'd6;
  logic [6:0] led_free = 7'h7f, led_auto = 7'h00, led_learn = 7'h44;
  logic [3:0] note_out;
  logic [6:0] led_out;
  logic [2:0] grant;
  logic       switching;

  int checks = 0;
  int failures = 0;
  int n;

  play_arbiter #(.MUTE_CYCLES(8), .GAP_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .note_free(note_free), .led_free(led_free),
    .note_auto(note_auto), .led_auto(led_auto),
    .note_learn(note_learn), .led_learn(led_learn),
    .note_out(note_out), .led_out(led_out), .grant(grant), .switching(switching)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] na;
    logic [6:0] la;
    logic [3:0] en;
    logic [6:0] el;
    logic [2:0] eg;
    logic       es;
  } vec_t;

  vec_t tbl[23];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] en, input logic [6:0] el,
                           input logic [2:0] eg, input logic es);
    check({name, "_note"}, {4'd0, note_out}, {4'd0, en});
    check({name, "_led"},  {1'b0, led_out},  {1'b0, el});
    check({name, "_grant"}, {5'd0, grant},   {5'd0, eg});
    check({name, "_sw"},   {7'd0, switching}, {7'd0, es});
  endtask

  // Counts consecutive switching cycles from the current sample; grant must stay 000.
  task automatic count_switching(input string name, output int cnt_out);
    cnt_out = 0;
    for (int i = 0; i < 40; i++) begin
      if (!switching) break;
      if (grant !== 3'b000) begin
        failures++;
        $display("FAIL %s_grant_in_mute actual=%0h required=0", name, grant);
      end
      cnt_out++;
      step();
    end
  endtask

  initial begin
    tbl[0] = '{3'b010, 4'd3, 7'h11, 4'd0, 7'h00, 3'b000, 1'b0};
    tbl[1] = '{3'b010, 4'd3, 7'h11, 4'd0, 7'h00, 3'b000, 1'b0};
    for (int i = 2; i <= 9; i++) tbl[i] = '{3'b010, 4'd3, 7'h11, 4'd0, 7'h00, 3'b000, 1'b1};
    tbl[10] = '{3'b010, 4'd3, 7'h11, 4'd0, 7'h11, 3'b010, 1'b0};
    tbl[11] = '{3'b010, 4'd3, 7'h11, 4'd3, 7'h11, 3'b010, 1'b0};
    tbl[12] = '{3'b010, 4'd3, 7'h11, 4'd3, 7'h11, 3'b010, 1'b0};
    tbl[13] = '{3'b010, 4'd5, 7'h22, 4'd0, 7'h22, 3'b010, 1'b0};
    tbl[14] = '{3'b010, 4'd5, 7'h22, 4'd0, 7'h22, 3'b010, 1'b0};
    tbl[15] = '{3'b010, 4'd5, 7'h33, 4'd0, 7'h33, 3'b010, 1'b0};
    tbl[16] = '{3'b010, 4'd5, 7'h33, 4'd0, 7'h33, 3'b010, 1'b0};
    tbl[17] = '{3'b010, 4'd5, 7'h33, 4'd5, 7'h33, 3'b010, 1'b0};
    tbl[18] = '{3'b010, 4'd5, 7'h33, 4'd5, 7'h33, 3'b010, 1'b0};
    tbl[19] = '{3'b010, 4'd0, 7'h33, 4'd5, 7'h33, 3'b010, 1'b0};
    tbl[20] = '{3'b010, 4'd3, 7'h33, 4'd0, 7'h33, 3'b010, 1'b0};
    tbl[21] = '{3'b010, 4'd3, 7'h33, 4'd3, 7'h33, 3'b010, 1'b0};
    tbl[22] = '{3'b010, 4'd3, 7'h33, 4'd3, 7'h33, 3'b010, 1'b0};

    // Reset held, then idle with mode=000.
    #2;
    check_all("reset", 4'd0, 7'h00, 3'b000, 1'b0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all($sformatf("idle%0d", i), 4'd0, 7'h00, 3'b000, 1'b0);
    end
    $display("idle after reset checked");

    // Mute on entry to auto, play, gap between 3->5, no gap through a rest.
    for (int i = 0; i < 23; i++) begin
      mode = tbl[i].mode;
      note_auto = tbl[i].na;
      led_auto = tbl[i].la;
      step();
      check_all($sformatf("row%0d", i), tbl[i].en, tbl[i].el, tbl[i].eg, tbl[i].es);
      $display("row %0d note=%0d led=%0h grant=%b sw=%b", i, note_out, led_out, grant, switching);
    end

    // Non-one-hot mode drops to IDLE after the synchronizer delay.
    mode = 3'b011;
    step(); check("pre_idle1_grant", {5'd0, grant}, 8'h02);
    step(); check("pre_idle2_grant", {5'd0, grant}, 8'h02);
    step(); check_all("idle011", 4'd0, 7'h00, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); check_all($sformatf("idle011_%0d", i), 4'd0, 7'h00, 3'b000, 1'b0);
    end
    mode = 3'b001;
    step(); step();
    check("learn_presync_sw", {7'd0, switching}, 8'h00);
    step();
    check("learn_mute_start", {7'd0, switching}, 8'h01);
    count_switching("learn", n);
    check("learn_mute_len", 8'(n), 8'd8);
    check_all("learn_grant", 4'd0, 7'h44, 3'b001, 1'b0);
    step();
    check_all("learn_play", 4'd6, 7'h44, 3'b001, 1'b0);
    $display("learn mode entered, mute length %0d", n);

    // Mode change in the middle of a gap: MUTE wins and runs a full 8 cycles.
    note_learn = 4'd2;
    step();
    check_all("learn_gap", 4'd0, 7'h44, 3'b001, 1'b0);
    mode = 3'b100;
    note_free = 4'd1;
    led_free = 7'h55;
    step(); step();
    check_all("gap_sync", 4'd0, 7'h44, 3'b001, 1'b0);
    step();
    check_all("gap_to_mute", 4'd0, 7'h00, 3'b000, 1'b1);
    count_switching("free", n);
    check("free_mute_len", 8'(n), 8'd8);
    check_all("free_grant", 4'd0, 7'h55, 3'b100, 1'b0);
    step();
    check_all("free_play", 4'd1, 7'h55, 3'b100, 1'b0);
    $display("gap interrupted by mode change, mute length %0d", n);

    // Reset pulse in the middle of MUTE: clears immediately, MUTE restarts from zero.
    mode = 3'b010;
    note_auto = 4'd3;
    led_auto = 7'h11;
    step(); step(); step();
    check("auto_mute_start", {7'd0, switching}, 8'h01);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1 check_all("async_rst_mute", 4'd0, 7'h00, 3'b000, 1'b0);
    step();
    rst_n = 1'b1;
    step(); step();
    check_all("post_rst_sync", 4'd0, 7'h00, 3'b000, 1'b0);
    step();
    check("post_rst_mute", {7'd0, switching}, 8'h01);
    count_switching("post_rst", n);
    check("post_rst_mute_len", 8'(n), 8'd8);
    check_all("post_rst_grant", 4'd0, 7'h11, 3'b010, 1'b0);
    step();
    check_all("post_rst_play", 4'd3, 7'h11, 3'b010, 1'b0);

    // Asynchronous reset while playing.
    #2 rst_n = 1'b0;
    #1 check_all("async_rst_play", 4'd0, 7'h00, 3'b000, 1'b0);
    $display("reset pulses checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
